// File: rtl/mux2to1_32b_reg.sv
// WIDTH-bit 2:1 word selector. It is built from gate-level bit slices and
// also provides a registered copy of the selected word with a valid flag.
module mux2to1_32b_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  // One inverter on select is shared by every slice.
  logic select_n;
  assign select_n = ~select;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      assign out[i] = (select_n & in1[i]) | (select & in2[i]);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux2to1_32b_reg.sv
// Scoreboard bench for mux2to1_32b_reg. The stimulus process queues the expected
// out, out_q and out_valid values, and a monitor process compares them against the DUT.
module tb_mux2to1_32b_reg;

  logic        clk;
  logic        reset;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        select;
  logic        en;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        out_valid;

  typedef struct {
    string       name;
    logic [31:0] e_out;
    logic [31:0] e_q;
    logic        e_v;
  } exp_t;

  exp_t sbq[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mq;
  logic        mv;

  mux2to1_32b_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .select(select),
    .en(en), .out(out), .out_q(out_q), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drain the scoreboard each time the stimulus announces a sample point.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (out !== e.e_out) begin
          errors++;
          $display("FAIL %s out: got %h expected %h", e.name, out, e.e_out);
        end
        checks++;
        if (out_q !== e.e_q) begin
          errors++;
          $display("FAIL %s out_q: got %h expected %h", e.name, out_q, e.e_q);
        end
        checks++;
        if (out_valid !== e.e_v) begin
          errors++;
          $display("FAIL %s out_valid: got %b expected %b", e.name, out_valid, e.e_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] exp_out);
    exp_t e;
    e.name  = name;
    e.e_out = exp_out;
    e.e_q   = mq;
    e.e_v   = mv;
    sbq.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Advance one rising edge. Inputs never change at an edge, so the current
  // reference word is also the pre-edge value.
  task automatic tick(input logic [31:0] cur);
    @(posedge clk);
    if (!reset && en) begin
      mq = cur;
      mv = 1'b1;
    end
    #1;
  endtask

  initial begin
    logic [32:0] wide;
    logic [31:0] w;
    logic [31:0] r;
    mq = '0;
    mv = 1'b0;

    reset  = 1'b1;
    en     = 1'b0;
    in1    = 32'hF0F0_F0F0;
    in2    = 32'hFFFF_FFFF;
    select = 1'b0;
    #2;
    check("reset_state", 32'hF0F0_F0F0);
    #1 reset = 1'b0;

    #16;
    wide   = 33'h1_FFFE_0000;
    in1    = 32'hF000_000F;
    in2    = wide[31:0];
    select = 1'b1;
    #1;
    check("trunc_sel1", 32'hFFFE_0000);

    en = 1'b1;
    tick(32'hFFFE_0000);
    check("load_en", 32'hFFFE_0000);
    en     = 1'b0;
    select = 1'b0;
    #1;
    check("sel0_comb", 32'hF000_000F);
    tick(32'hF000_000F);
    check("hold_en0", 32'hF000_000F);

    #2 reset = 1'b1;
    mq = '0;
    mv = 1'b0;
    #1;
    check("async_reset", 32'hF000_000F);
    en = 1'b1;
    tick(32'hF000_000F);
    check("reset_dominates_1", 32'hF000_000F);
    tick(32'hF000_000F);
    check("reset_dominates_2", 32'hF000_000F);
    #2 reset = 1'b0;
    tick(32'hF000_000F);
    check("first_load_after_reset", 32'hF000_000F);
    en = 1'b0;

    for (int k = 0; k < 32; k++) begin
      w   = 32'h1 << k;
      in1 = w;
      in2 = ~w;
      select = 1'b0;
      #1;
      check($sformatf("walk%0d_s0", k), w);
      select = 1'b1;
      #1;
      check($sformatf("walk%0d_s1", k), ~w);
    end

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in1    = $urandom;
      in2    = $urandom;
      select = 1'($urandom_range(0, 1));
      en     = 1'($urandom_range(0, 1));
      #1;
      r = select ? in2 : in1;
      check($sformatf("rand%0d_comb", n), r);
      tick(r);
      check($sformatf("rand%0d_reg", n), r);
    end

    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
